fft_spectrum_buffer: RTL and testbench
======================================

# fft_spectrum_buffer

Receiving end of the FFT magnitude stream. Captures one frame of N_POINTS bin magnitudes delimited by sop/eop/valid into a ping-pong RAM, checks frame length, and publishes complete frames to the LCD bar renderer through a random-access read port. Also reports the peak bin of each published frame. A frame is only ever published whole; the renderer never sees a partial or malformed frame.

## Interface
- N_POINTS, 128, bins per frame (power of two)
- DATA_W, 16, magnitude width
- ADDR_W, 7, log2(N_POINTS)
- sys_clk  in  1  clock; all logic on rising edge
- sys_rst  in  1  reset, asynchronous, active-low
- in_data  in  DATA_W  bin magnitude
- in_sop / in_eop / in_valid  in  1  frame delimiters and qualifier; sop and eop are meaningful only when in_valid=1
- hold  in  1  renderer is mid-draw; defers publishing
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  bin index to read
- rd_data  out  DATA_W  read data from the display bank
- rd_valid  out  1  rd_data is valid
- frame_ready  out  1  one-cycle pulse when a new frame is published
- peak_val  out  DATA_W  largest magnitude in the published frame
- peak_bin  out  ADDR_W  index of that magnitude
- err_cnt  out  8  count of malformed frames; saturates at 255
- drop_cnt  out  8  count of well-formed frames discarded; saturates at 255

## Operation
- Two banks of N_POINTS x DATA_W. wr_bank = ~disp_bank. RAM contents are not reset.
- FSM states: IDLE, CAPTURE, PENDING.
- IDLE
  - Beats without sop are ignored.
  - A valid sop with no eop writes bin 0, sets wr_addr=1, initialises the running peak to (in_data, 0), and enters CAPTURE.
- CAPTURE: each valid beat writes in_data at wr_addr.
  - in_data strictly greater than the running peak replaces it, so ties keep the lowest index.
  - Valid eop with wr_addr==N_POINTS-1 is good.
    - If hold=0: publish and return to IDLE.
    - If hold=1: go to PENDING.
  - Valid eop with wr_addr!=N_POINTS-1: err_cnt+1, discard, go to IDLE.
  - Valid sop mid-frame: err_cnt+1, then restart capture at bin 0 with this beat.
  - Valid beat at wr_addr==N_POINTS-1 without eop: err_cnt+1, discard, go to IDLE.
  - Beats with in_valid=0 change nothing.
- Valid sop and eop on the same beat: err_cnt+1, nothing written, state becomes IDLE.
- PENDING
  - Waits for hold=0, then publishes and returns to IDLE.
  - Valid sop arriving here: the whole incoming frame through its eop (or until the next valid sop) is ignored and not written, and drop_cnt+1.
  - If that frame ends by a valid eop, the block returns to PENDING if the publish has not yet happened, otherwise to IDLE.
- Publish
  - Toggles disp_bank.
  - Latches peak_val/peak_bin.
  - Pulses frame_ready.
- Read port
  - rd_en=1 at edge k gives rd_data = disp_bank[rd_addr] and rd_valid=1 after edge k+1.
  - rd_valid=0 otherwise; rd_data holds its last value.

## Timing
- Reset values
  - rd_data=0, rd_valid=0, frame_ready=0, peak_val=0, peak_bin=0, err_cnt=0, drop_cnt=0.
  - disp_bank=0, state=IDLE, wr_addr=0.
- Input sampled at edge e; RAM write completes at edge e.
- Good eop sampled at edge e with hold=0: disp_bank, peak_* and frame_ready=1 are updated at edge e+1. frame_ready is 0 again after edge e+2.
  - A read sampled at edge e+1 uses the old bank.
  - A read sampled at edge e+2 or later uses the new bank.
- In PENDING, hold sampled 0 at edge h: publish at edge h+1, with the same visibility rule.
- Read latency is 1 cycle. Back-to-back reads are allowed, one per cycle.
- The write bank never equals the display bank, so a simultaneous read and write never collide.
- Counters update 1 cycle after the offending beat. At 255 they stay at 255.
- Reset mid-frame:
  - Discards the capture.
  - Outputs return to reset values immediately.
  - Capture needs a new sop.

## Test plan
- Good frame, hold=0, in_data=bin index (0..127) → one frame_ready pulse 1 cycle after eop; reading bins 0..127 returns 0..127 with 1-cycle latency; peak_val=127, peak_bin=127.
- Short frame: eop on bin 99 → err_cnt=1, no frame_ready, reads still return the previous frame. A following good frame publishes normally.
- Restart and overrun:
  - sop at bin 50 → err_cnt+1, the new frame captured from bin 0 publishes correctly.
  - 128 beats with no eop → err_cnt+1, return to IDLE.
- Hold while the renderer draws: hold=1 across eop, then a second full frame arrives → first frame publishes 1 cycle after hold falls, second frame dropped (drop_cnt=1), display unchanged during hold.
- Ties and gaps: all bins 0x0100 except bins 10 and 90 = 0x8000, in_valid toggling every other cycle → peak_val=0x8000, peak_bin=10, contents intact.
- Reset and saturation:
  - Assert sys_rst mid-capture → all outputs 0 asynchronously; the next good frame publishes to bank 1.
  - 300 malformed frames → err_cnt=255.

Source files
------------

// File: rtl/fft_spectrum_buffer_if.sv
// FFT spectrum buffer port bundle.
// Magnitude stream in, renderer read port and frame status out.
interface fft_spectrum_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7
);
  logic [DATA_W-1:0] in_data;
  logic              in_sop;
  logic              in_eop;
  logic              in_valid;
  logic              hold;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              frame_ready;
  logic [DATA_W-1:0] peak_val;
  logic [ADDR_W-1:0] peak_bin;
  logic [7:0]        err_cnt;
  logic [7:0]        drop_cnt;

  modport master (
    output in_data, in_sop, in_eop, in_valid,
    output hold, rd_en, rd_addr,
    input  rd_data, rd_valid, frame_ready,
    input  peak_val, peak_bin, err_cnt, drop_cnt
  );

  modport slave (
    input  in_data, in_sop, in_eop, in_valid,
    input  hold, rd_en, rd_addr,
    output rd_data, rd_valid, frame_ready,
    output peak_val, peak_bin, err_cnt, drop_cnt
  );
endinterface

// File: rtl/fft_spectrum_buffer.sv
// Ping-pong capture of one FFT magnitude frame with length checking,
// peak tracking and whole-frame publishing to the bar renderer.
module fft_spectrum_buffer #(
  parameter int N_POINTS = 128,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 7
) (
  input logic               sys_clk,
  input logic               sys_rst,
  fft_spectrum_buffer_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] PENDING = 2'd2;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_POINTS - 1);

  logic [DATA_W-1:0] mem [2*N_POINTS];

  logic [1:0]        state, state_n;
  logic [ADDR_W-1:0] wr_addr, wr_addr_n;
  logic [DATA_W-1:0] run_val, run_val_n;
  logic [ADDR_W-1:0] run_bin, run_bin_n;
  logic              skip, skip_n;
  logic              disp_bank;
  logic              pub_go, pub_set;
  logic              wr_en, wr_bank;
  logic [ADDR_W-1:0] wr_idx;
  logic              err_inc, drop_inc;

  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              frame_ready;
  logic [DATA_W-1:0] peak_val;
  logic [ADDR_W-1:0] peak_bin;
  logic [7:0]        err_cnt, drop_cnt;

  logic sop, eop, beat, last, greater;

  assign beat    = bus.in_valid;
  assign sop     = beat & bus.in_sop;
  assign eop     = beat & bus.in_eop;
  assign last    = (wr_addr == LAST);
  assign greater = (bus.in_data > run_val);

  // Between the good eop and the bank toggle the fresh frame still sits
  // in ~disp_bank, so a new capture must already target disp_bank.
  assign wr_bank = pub_go ? disp_bank : ~disp_bank;

  always_comb begin
    state_n   = state;
    wr_addr_n = wr_addr;
    run_val_n = run_val;
    run_bin_n = run_bin;
    skip_n    = skip;
    pub_set   = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = wr_addr;
    err_inc   = 1'b0;
    drop_inc  = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (sop && eop) begin
          err_inc = 1'b1;
          skip_n  = 1'b0;
        end else if (sop) begin
          skip_n    = 1'b0;
          wr_en     = 1'b1;
          wr_idx    = '0;
          wr_addr_n = ADDR_W'(1);
          run_val_n = bus.in_data;
          run_bin_n = '0;
          state_n   = CAPTURE;
        end else if (eop) begin
          skip_n = 1'b0;
        end
      end
      (state == CAPTURE): begin
        if (sop && eop) begin
          err_inc   = 1'b1;
          wr_addr_n = '0;
          state_n   = IDLE;
        end else if (sop) begin
          err_inc   = 1'b1;
          wr_en     = 1'b1;
          wr_idx    = '0;
          wr_addr_n = ADDR_W'(1);
          run_val_n = bus.in_data;
          run_bin_n = '0;
        end else if (beat) begin
          wr_en = 1'b1;
          if (greater) begin
            run_val_n = bus.in_data;
            run_bin_n = wr_addr;
          end
          if (eop && last) begin
            wr_addr_n = '0;
            if (bus.hold) begin
              state_n = PENDING;
            end else begin
              pub_set = 1'b1;
              state_n = IDLE;
            end
          end else if (eop || last) begin
            err_inc   = 1'b1;
            wr_addr_n = '0;
            state_n   = IDLE;
          end else begin
            wr_addr_n = wr_addr + ADDR_W'(1);
          end
        end
      end
      default: begin
        if (!bus.hold) begin
          pub_set = 1'b1;
          state_n = IDLE;
        end
        // skip outlives PENDING so a dropped frame is still swallowed
        if (sop && eop) begin
          err_inc = 1'b1;
          skip_n  = 1'b0;
        end else if (sop) begin
          drop_inc = 1'b1;
          skip_n   = 1'b1;
        end else if (eop) begin
          skip_n = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[{wr_bank, wr_idx}] <= bus.in_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state       <= IDLE;
      wr_addr     <= '0;
      run_val     <= '0;
      run_bin     <= '0;
      skip        <= 1'b0;
      disp_bank   <= 1'b0;
      pub_go      <= 1'b0;
      frame_ready <= 1'b0;
      peak_val    <= '0;
      peak_bin    <= '0;
      err_cnt     <= '0;
      drop_cnt    <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
    end else begin
      state       <= state_n;
      wr_addr     <= wr_addr_n;
      run_val     <= run_val_n;
      run_bin     <= run_bin_n;
      skip        <= skip_n;
      pub_go      <= pub_set;
      frame_ready <= pub_go;
      if (pub_go) begin
        disp_bank <= ~disp_bank;
        peak_val  <= run_val;
        peak_bin  <= run_bin;
      end
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      rd_valid <= bus.rd_en;
      if (bus.rd_en) rd_data <= mem[{disp_bank, bus.rd_addr}];
    end
  end

  assign bus.rd_data     = rd_data;
  assign bus.rd_valid    = rd_valid;
  assign bus.frame_ready = frame_ready;
  assign bus.peak_val    = peak_val;
  assign bus.peak_bin    = peak_bin;
  assign bus.err_cnt     = err_cnt;
  assign bus.drop_cnt    = drop_cnt;

endmodule

// File: tb/tb_fft_spectrum_buffer.sv
// Directed scoreboard bench for fft_spectrum_buffer.
// Read results are queued at issue and checked on rd_valid.
module tb_fft_spectrum_buffer;
  localparam int N  = 128;
  localparam int DW = 16;
  localparam int AW = 7;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  fft_spectrum_buffer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  fft_spectrum_buffer #(
    .N_POINTS(N), .DATA_W(DW), .ADDR_W(AW)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;

  int ntests   = 0;
  int nfail    = 0;
  int fr_seen  = 0;
  int exp_pubs = 0;

  logic [DW-1:0] frm      [N];
  logic [DW-1:0] exp_disp [N];
  logic [DW-1:0] exp_next [N];
  logic [DW-1:0] exp_q    [$];
  logic [DW-1:0] pk_val;
  logic [AW-1:0] pk_bin;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (bus.frame_ready) fr_seen++;
    if (bus.rd_valid) begin
      if (exp_q.size() == 0) chk("rd_extra", {31'b0, bus.rd_valid}, 0);
      else chk("rd_data", bus.rd_data, exp_q.pop_front());
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i++) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = AW'(i);
      exp_q.push_back(exp_disp[i]);
      tick();
    end
    bus.rd_en = 1'b0;
    tick();
    chk("rd_drain", exp_q.size(), 0);
  endtask

  task automatic send_beats(input int n, input bit with_eop, input bit gaps);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sop   = (i == 0);
      bus.in_eop   = with_eop && (i == n - 1);
      bus.in_data  = frm[i];
      tick();
      if (gaps && i != n - 1) begin
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'($urandom_range(0, 1));
        bus.in_eop   = 1'($urandom_range(0, 1));
        tick();
      end
    end
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  task automatic calc_peak();
    pk_val = frm[0];
    pk_bin = '0;
    for (int i = 1; i < N; i++)
      if (frm[i] > pk_val) begin
        pk_val = frm[i];
        pk_bin = AW'(i);
      end
    exp_next = frm;
  endtask

  // Called right after the edge that sampled the publishing condition.
  task automatic expect_publish(input bit probe);
    chk("fr_early", bus.frame_ready, 0);
    if (probe) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = AW'(3);
      exp_q.push_back(exp_disp[3]);
    end
    tick();
    chk("fr_pulse", bus.frame_ready, 1);
    chk("peak_val", bus.peak_val, pk_val);
    chk("peak_bin", bus.peak_bin, pk_bin);
    exp_disp = exp_next;
    exp_pubs++;
    if (probe) exp_q.push_back(exp_disp[3]);
    tick();
    chk("fr_clear", bus.frame_ready, 0);
    bus.rd_en = 1'b0;
    tick();
  endtask

  initial begin
    bus.in_data  = '0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
    bus.in_valid = 1'b0;
    bus.hold     = 1'b0;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = '0;
    tick();
    tick();
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_frame_ready", bus.frame_ready, 0);
    chk("rst_peak_val", bus.peak_val, 0);
    chk("rst_peak_bin", bus.peak_bin, 0);
    chk("rst_err", bus.err_cnt, 0);
    chk("rst_drop", bus.drop_cnt, 0);
    sys_rst = 1'b1;
    tick();

    // good frame, ramp data
    for (int i = 0; i < N; i++) frm[i] = DW'(i);
    send_beats(N, 1'b1, 1'b0);
    calc_peak();
    expect_publish(1'b0);
    read_all();
    chk("t1_err", bus.err_cnt, 0);
    chk("t1_peak_val", bus.peak_val, 16'd127);
    chk("t1_peak_bin", bus.peak_bin, 7'd127);

    // short frame
    for (int i = 0; i < N; i++) frm[i] = DW'(16'h1000 + i);
    send_beats(100, 1'b1, 1'b0);
    tick();
    chk("t2_err", bus.err_cnt, 1);
    tick();
    read_all();
    chk("t2_pubs", fr_seen, exp_pubs);

    // restart mid-frame then a good frame
    for (int i = 0; i < N; i++) frm[i] = DW'(16'h0200 + ((i * 37) % 128));
    send_beats(50, 1'b0, 1'b0);
    send_beats(N, 1'b1, 1'b0);
    calc_peak();
    expect_publish(1'b1);
    read_all();
    chk("t3_err", bus.err_cnt, 2);

    // overrun
    for (int i = 0; i < N; i++) frm[i] = DW'(16'hFFFF - i);
    send_beats(N, 1'b0, 1'b0);
    tick();
    chk("t4_err", bus.err_cnt, 3);
    read_all();
    chk("t4_pubs", fr_seen, exp_pubs);

    // hold across eop, second frame dropped
    bus.hold = 1'b1;
    for (int i = 0; i < N; i++) frm[i] = DW'(16'h3000 ^ i);
    send_beats(N, 1'b1, 1'b0);
    calc_peak();
    repeat (3) tick();
    chk("t5_hold_pubs", fr_seen, exp_pubs);
    for (int i = 0; i < N; i++) frm[i] = DW'(16'h7000 + i);
    send_beats(N, 1'b1, 1'b0);
    tick();
    chk("t5_drop", bus.drop_cnt, 1);
    read_all();
    chk("t5_hold_pubs2", fr_seen, exp_pubs);
    bus.hold = 1'b0;
    tick();
    expect_publish(1'b1);
    read_all();
    chk("t5_drop_after", bus.drop_cnt, 1);
    chk("t5_err", bus.err_cnt, 3);

    // ties and gaps
    for (int i = 0; i < N; i++) frm[i] = 16'h0100;
    frm[10] = 16'h8000;
    frm[90] = 16'h8000;
    send_beats(N, 1'b1, 1'b1);
    calc_peak();
    expect_publish(1'b1);
    chk("t6_peak_val", bus.peak_val, 16'h8000);
    chk("t6_peak_bin", bus.peak_bin, 7'd10);
    read_all();

    // async reset mid-capture
    for (int i = 0; i < N; i++) frm[i] = DW'(16'h4000 + i);
    send_beats(60, 1'b0, 1'b0);
    #2;
    sys_rst = 1'b0;
    #1;
    chk("ar_frame_ready", bus.frame_ready, 0);
    chk("ar_rd_valid", bus.rd_valid, 0);
    chk("ar_rd_data", bus.rd_data, 0);
    chk("ar_peak_val", bus.peak_val, 0);
    chk("ar_peak_bin", bus.peak_bin, 0);
    chk("ar_err", bus.err_cnt, 0);
    chk("ar_drop", bus.drop_cnt, 0);
    tick();
    sys_rst = 1'b1;
    tick();
    for (int i = 0; i < N; i++) frm[i] = DW'(16'h5000 + (127 - i));
    send_beats(N, 1'b1, 1'b0);
    calc_peak();
    expect_publish(1'b0);
    read_all();
    chk("t7_err", bus.err_cnt, 0);

    // saturation with sop+eop beats
    repeat (300) begin
      bus.in_valid = 1'b1;
      bus.in_sop   = 1'b1;
      bus.in_eop   = 1'b1;
      bus.in_data  = 16'hABCD;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
    tick();
    chk("t8_err_sat", bus.err_cnt, 255);
    chk("t8_drop", bus.drop_cnt, 0);
    chk("t8_pubs", fr_seen, exp_pubs);
    read_all();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
